// File: rtl/fetch_ctrl_if.sv
// ============================================================================
// fetch_ctrl_if : front-end sequencing bus between core control and fetch_ctrl
// Revision 1.0  : initial release
// ============================================================================
`default_nettype none

interface fetch_ctrl_if #(
   parameter int PC_WIDTH = 32
);
   logic                stall;
   logic                imem_ready;
   logic                halt_req;
   logic                resume;
   logic                trap_valid;
   logic                br_valid;
   logic [PC_WIDTH-1:0] br_target;
   logic                jmp_valid;
   logic [PC_WIDTH-1:0] jmp_target;
   logic                pc_en;
   logic                pc_override;
   logic [PC_WIDTH-1:0] pc_in;
   logic                flush;
   logic                fetch_valid;
   logic                halted;
   logic [1:0]          redirect_src;

   modport master (
      output stall, imem_ready, halt_req, resume,
      output trap_valid, br_valid, br_target, jmp_valid, jmp_target,
      input  pc_en, pc_override, pc_in, flush, fetch_valid, halted, redirect_src
   );

   modport slave (
      input  stall, imem_ready, halt_req, resume,
      input  trap_valid, br_valid, br_target, jmp_valid, jmp_target,
      output pc_en, pc_override, pc_in, flush, fetch_valid, halted, redirect_src
   );
endinterface

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// fetch_ctrl : PC sequencing controller (redirect priority, flush window, halt)
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module fetch_ctrl #(
   parameter int          PC_WIDTH     = 32,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int          FLUSH_CYCLES = 2
) (
   input  wire           clk,
   input  wire           rst,
   fetch_ctrl_if.slave   bus
);

   localparam logic [PC_WIDTH-1:0] c_trap_pc    = PC_WIDTH'(TRAP_VECTOR);
   localparam logic [3:0]          c_flush_init = 4'(FLUSH_CYCLES);

   typedef enum logic [2:0] {
      S_BOOT  = 3'd0,
      S_RUN   = 3'd1,
      S_REDIR = 3'd2,
      S_FLUSH = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [3:0]          r_cnt, w_cnt_nxt;
   logic                r_pc_en, w_pc_en_nxt;
   logic                r_pc_override, w_pc_override_nxt;
   logic [PC_WIDTH-1:0] r_pc_in, w_pc_in_nxt;
   logic                r_flush, w_flush_nxt;
   logic                r_fetch_valid, w_fetch_valid_nxt;
   logic                r_halted, w_halted_nxt;
   logic [1:0]          r_src, w_src_nxt;

   logic                w_any_redir;
   logic                w_take;
   logic                w_go;

   assign w_any_redir = bus.trap_valid | bus.br_valid | bus.jmp_valid;
   assign w_go        = !bus.stall && bus.imem_ready;

   always_comb begin
      w_state_nxt       = r_state;
      w_cnt_nxt         = r_cnt;
      w_pc_in_nxt       = r_pc_in;
      w_src_nxt         = r_src;
      w_take            = 1'b0;
      w_pc_en_nxt       = 1'b0;
      w_pc_override_nxt = 1'b0;
      w_flush_nxt       = 1'b0;
      w_fetch_valid_nxt = 1'b0;
      w_halted_nxt      = 1'b0;

      case (r_state)
         S_BOOT: w_state_nxt = S_RUN;
         S_RUN: begin
            if (w_any_redir)       w_take      = 1'b1;
            else if (bus.halt_req) w_state_nxt = S_HALT;
            else                   w_state_nxt = S_RUN;
         end
         S_REDIR: begin
            if (w_any_redir) begin
               w_take = 1'b1;
            end else if (c_flush_init == 4'd0) begin
               w_state_nxt = S_RUN;
            end else begin
               w_state_nxt = S_FLUSH;
               w_cnt_nxt   = c_flush_init;
            end
         end
         S_FLUSH: begin
            if (w_any_redir) begin
               w_take = 1'b1;
            end else begin
               // Only fetches that were actually issued consume the window.
               if (r_pc_en && (r_cnt != 4'd0)) w_cnt_nxt = r_cnt - 4'd1;
               w_state_nxt = (w_cnt_nxt == 4'd0) ? S_RUN : S_FLUSH;
            end
         end
         S_HALT: begin
            if (bus.trap_valid)  w_take      = 1'b1;
            else if (bus.resume) w_state_nxt = S_RUN;
            else                 w_state_nxt = S_HALT;
         end
         default: w_state_nxt = S_BOOT;
      endcase

      if (w_take) begin
         w_state_nxt = S_REDIR;
         if (bus.trap_valid) begin
            w_pc_in_nxt = c_trap_pc;
            w_src_nxt   = 2'd3;
         end else if (bus.br_valid) begin
            w_pc_in_nxt = bus.br_target;
            w_src_nxt   = 2'd2;
         end else begin
            w_pc_in_nxt = bus.jmp_target;
            w_src_nxt   = 2'd1;
         end
      end

      case (w_state_nxt)
         S_RUN: begin
            w_pc_en_nxt       = w_go;
            w_fetch_valid_nxt = w_go;
         end
         S_REDIR: begin
            w_pc_en_nxt       = 1'b1;
            w_pc_override_nxt = 1'b1;
            w_flush_nxt       = 1'b1;
         end
         S_FLUSH: w_pc_en_nxt  = w_go;
         S_HALT:  w_halted_nxt = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_BOOT;
         r_cnt         <= 4'd0;
         r_pc_en       <= 1'b0;
         r_pc_override <= 1'b0;
         r_pc_in       <= '0;
         r_flush       <= 1'b0;
         r_fetch_valid <= 1'b0;
         r_halted      <= 1'b0;
         r_src         <= 2'd0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_pc_en       <= w_pc_en_nxt;
         r_pc_override <= w_pc_override_nxt;
         r_pc_in       <= w_pc_in_nxt;
         r_flush       <= w_flush_nxt;
         r_fetch_valid <= w_fetch_valid_nxt;
         r_halted      <= w_halted_nxt;
         r_src         <= w_src_nxt;
      end
   end

   assign bus.pc_en        = r_pc_en;
   assign bus.pc_override  = r_pc_override;
   assign bus.pc_in        = r_pc_in;
   assign bus.flush        = r_flush;
   assign bus.fetch_valid  = r_fetch_valid;
   assign bus.halted       = r_halted;
   assign bus.redirect_src = r_src;

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// tb_fetch_ctrl : directed + randomized bench for fetch_ctrl with a cycle model
// Revision 1.0  : initial release
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

   localparam int          PC_WIDTH     = 32;
   localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0100;
   localparam int          FLUSH_CYCLES = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_ctrl_if #(.PC_WIDTH(PC_WIDTH)) bus ();

   fetch_ctrl #(
      .PC_WIDTH     (PC_WIDTH),
      .TRAP_VECTOR  (TRAP_VECTOR),
      .FLUSH_CYCLES (FLUSH_CYCLES)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: expected outputs for the current cycle plus bookkeeping
   logic        e_pc_en, e_ovr, e_flush, e_fv, e_halted;
   logic [1:0]  e_src;
   logic [31:0] e_pc_in;
   bit          m_boot, m_redir;
   int          m_squash;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_reset();
      e_pc_en = 0; e_ovr = 0; e_flush = 0; e_fv = 0; e_halted = 0;
      e_src = 0; e_pc_in = 0;
      m_boot = 1; m_redir = 0; m_squash = 0;
   endtask

   task automatic model_edge();
      bit any, go, accept, to_run, to_flush, to_halt;
      any = bus.trap_valid | bus.br_valid | bus.jmp_valid;
      go  = !bus.stall && bus.imem_ready;
      to_run = 0; to_flush = 0; to_halt = 0;
      accept = !m_boot && (e_halted ? bus.trap_valid : any);
      if (accept) begin
         if (bus.trap_valid)    begin e_pc_in = TRAP_VECTOR;    e_src = 3; end
         else if (bus.br_valid) begin e_pc_in = bus.br_target;  e_src = 2; end
         else                   begin e_pc_in = bus.jmp_target; e_src = 1; end
      end else if (m_boot) begin
         to_run = 1;
      end else if (e_halted) begin
         if (bus.resume) to_run = 1; else to_halt = 1;
      end else if (m_redir) begin
         m_squash = FLUSH_CYCLES;
         if (m_squash == 0) to_run = 1; else to_flush = 1;
      end else if (m_squash > 0) begin
         if (e_pc_en) m_squash--;
         if (m_squash == 0) to_run = 1; else to_flush = 1;
      end else begin
         if (bus.halt_req) to_halt = 1; else to_run = 1;
      end
      m_boot   = 0;
      m_redir  = accept;
      e_ovr    = accept;
      e_flush  = accept;
      e_pc_en  = accept | ((to_run | to_flush) & go);
      e_fv     = to_run & go;
      e_halted = to_halt;
   endtask

   task automatic compare_all();
      check("pc_en",        bus.pc_en,        e_pc_en);
      check("pc_override",  bus.pc_override,  e_ovr);
      check("pc_in",        bus.pc_in,        e_pc_in);
      check("flush",        bus.flush,        e_flush);
      check("fetch_valid",  bus.fetch_valid,  e_fv);
      check("halted",       bus.halted,       e_halted);
      check("redirect_src", bus.redirect_src, e_src);
   endtask

   task automatic cycle();
      @(posedge clk);
      if (!rst) model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic drive(input bit st, input bit rdy, input bit hr, input bit rs,
                        input bit tv, input bit bv, input logic [31:0] bt,
                        input bit jv, input logic [31:0] jt);
      bus.stall = st; bus.imem_ready = rdy; bus.halt_req = hr; bus.resume = rs;
      bus.trap_valid = tv; bus.br_valid = bv; bus.br_target = bt;
      bus.jmp_valid = jv; bus.jmp_target = jt;
      cycle();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Release lands just after a rising edge so BOOT spans one full cycle.
   task automatic release_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      compare_all();
   endtask

   task automatic async_reset_now();
      #1 rst = 1'b1;
      #1;
      model_reset();
      compare_all();
      idle(1);
      release_reset();
   endtask

   initial begin
      bus.stall = 0; bus.imem_ready = 1; bus.halt_req = 0; bus.resume = 0;
      bus.trap_valid = 0; bus.br_valid = 0; bus.br_target = 0;
      bus.jmp_valid = 0; bus.jmp_target = 0;
      model_reset();
      @(negedge clk);
      compare_all();
      idle(2);
      release_reset();

      idle(4);
      drive(0, 1, 0, 0, 0, 1, 32'd15, 0, 0);
      idle(4);
      drive(0, 1, 0, 0, 1, 1, 32'd40, 1, 32'd80);
      idle(4);
      for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
      drive(0, 1, 0, 0, 0, 0, 0, 1, 32'd30);
      idle(1);
      drive(0, 1, 0, 0, 0, 1, 32'd50, 0, 0);
      idle(5);
      drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 1, 32'd77, 1, 32'd99);
      drive(0, 1, 0, 0, 1, 0, 0, 0, 0);
      idle(4);
      drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
      idle(1);
      drive(0, 1, 0, 1, 1, 0, 0, 0, 0);
      idle(3);
      drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
      drive(0, 1, 0, 1, 0, 0, 0, 0, 0);
      idle(2);
      drive(0, 1, 0, 0, 0, 0, 0, 1, 32'd123);
      idle(2);
      async_reset_now();
      idle(3);

      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 8),
               ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 24) == 0), ($urandom_range(0, 11) == 0), $urandom,
               ($urandom_range(0, 11) == 0), $urandom);
         if ($urandom_range(0, 199) == 0) async_reset_now();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencing controller for the program counter (pc_ctr).
- Generates pc_ctr's en, pc_override and pc_in from backend stall, instruction-memory readiness, halt/resume and three prioritized redirect sources (trap > branch > jump).
- Owns the post-redirect flush window and marks which fetch slots are valid.
- Sits between the core's execute/exception logic and pc_ctr at the front of the fetch stage.

Parameters:
PC_WIDTH, 32, width of PC and all target buses
TRAP_VECTOR, 32'h0000_0100, target PC on trap redirect (truncated to PC_WIDTH)
FLUSH_CYCLES, 2, cycles fetch_valid stays low after a redirect (0 allowed; valid range 0..15)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
stall  in  1  backend stall request
imem_ready  in  1  instruction memory can accept a fetch this cycle
halt_req  in  1  request to halt fetch
resume  in  1  leave HALT
trap_valid  in  1  trap redirect request
br_valid  in  1  branch redirect request
br_target  in  PC_WIDTH  branch target
jmp_valid  in  1  jump redirect request
jmp_target  in  PC_WIDTH  jump target
pc_en  out  1  drives pc_ctr en
pc_override  out  1  drives pc_ctr pc_override
pc_in  out  PC_WIDTH  drives pc_ctr pc_in
flush  out  1  one-cycle pulse: squash in-flight fetches
fetch_valid  out  1  current fetch slot carries a valid instruction
halted  out  1  controller is in HALT
redirect_src  out  2  source of the latest accepted redirect: 0 none, 1 jump, 2 branch, 3 trap

Behaviour:
- All outputs are registered. Inputs sampled at edge N determine outputs during cycle N+1.
- Reset (async assert): state=BOOT; pc_en=0, pc_override=0, pc_in=0, flush=0, fetch_valid=0, halted=0, redirect_src=0; flush counter=0.
- Reset asserted mid-flush or mid-halt aborts everything and returns to BOOT.
- States: BOOT, RUN, REDIR, FLUSH, HALT.
- BOOT: lasts exactly one cycle after rst deasserts, outputs held at reset values; then RUN.
- Redirect accept: any of trap_valid, br_valid or jmp_valid high in RUN, REDIR or FLUSH.
  - Winner by priority: trap > branch > jump. The losers are dropped, not queued.
  - Next cycle (state REDIR): pc_override=1, pc_en=1, pc_in=target (TRAP_VECTOR/br_target/jmp_target), flush=1, fetch_valid=0, redirect_src=winner code.
  - stall and imem_ready are ignored during the accept and the REDIR cycle.
- From REDIR (no new redirect): FLUSH with counter=FLUSH_CYCLES.
  - If FLUSH_CYCLES=0, go directly to RUN.
- FLUSH: pc_override=0, flush=0, fetch_valid=0, pc_en=!stall && imem_ready.
  - Counter decrements only on cycles where pc_en=1.
  - RUN is entered the cycle after the counter reaches 0.
- A new redirect accepted in REDIR or FLUSH restarts the sequence: REDIR next cycle, latest target wins.
- RUN, each cycle: pc_en=!stall && imem_ready; fetch_valid=pc_en; pc_override=0; flush=0.
  - pc_in holds its last value and is don't-care when pc_override=0.
- halt_req in RUN with no redirect: HALT next cycle; pc_en=0, fetch_valid=0, halted=1.
- Redirect and halt_req in the same cycle: the redirect wins and halt_req is dropped.
- halt_req is ignored in BOOT, REDIR and FLUSH.
- HALT:
  - trap_valid → REDIR (halted=0 next cycle).
  - Else resume → RUN (halted=0 next cycle).
  - br_valid and jmp_valid are ignored.
  - trap_valid and resume together → trap wins.
- redirect_src holds until the next accepted redirect or reset.
- Counter width: 4 bits, saturating at 0, no wrap.

Test Plan:
1. Reset then run: rst high 2 cycles, release, stall=0, imem_ready=1 → one BOOT cycle with pc_en=0, then pc_en=1 and fetch_valid=1 every cycle; pc_ctr advances 0,1,2,...
2. Branch redirect: at RUN cycle N, br_valid=1, br_target=15 → cycle N+1: pc_override=1, pc_in=15, flush=1, redirect_src=2; the next 2 cycles fetch_valid=0 with pc_en=1; then fetch_valid=1; pc_ctr reads 15,16,17,18.
3. Simultaneous sources: trap_valid, br_valid (target 40) and jmp_valid (target 80) all high for one cycle → pc_in=0x100, redirect_src=3; 40 and 80 never appear on pc_in.
4. Stall/imem gating: in RUN hold stall=1 for 3 cycles, then imem_ready=0 for 2 cycles → pc_en=0 and fetch_valid=0 for exactly 5 cycles, starting one cycle after each input change; PC value frozen.
5. Redirect during flush: with FLUSH_CYCLES=2, jmp_valid (target 30) accepted, then br_valid (target 50) on the first FLUSH cycle → second REDIR with pc_in=50; a full 2-cycle flush restarts; resulting PCs are 50,51,...
6. Halt/resume/trap and reset mid-op: halt_req → halted=1, pc_en=0; br_valid ignored while halted; trap_valid → REDIR with pc_in=0x100, halted=0. Repeat halt, then resume → RUN. Assert rst during FLUSH → all outputs 0 immediately (async), BOOT after release.
